// File: rtl/reservation_station_ooo_if.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station_ooo_if
// Brief    : Dispatch, issue, CDB and status bundle of the reservation station.
// Revision : 1.0 - initial release
// ============================================================================
interface reservation_station_ooo_if #(
    parameter int N_OPERANDS  = 2,
    parameter int N_ENTRIES_W = 3,
    parameter int N_CDB       = 2,
    parameter int TAG_W       = 4,
    parameter int DATA_W      = 32,
    parameter int INSTR_W     = 8
);
    logic                         flush;
    logic                         i_valid;
    logic                         i_ready;
    logic [TAG_W-1:0]             i_dest;
    logic [INSTR_W-1:0]           i_instr;
    logic [N_OPERANDS*TAG_W-1:0]  i_src_tag;
    logic [N_OPERANDS*DATA_W-1:0] i_src_data;
    logic [N_OPERANDS-1:0]        i_filled;
    logic                         o_valid;
    logic                         o_ready;
    logic [TAG_W-1:0]             o_dest;
    logic [INSTR_W-1:0]           o_instr;
    logic [N_OPERANDS*DATA_W-1:0] o_src_data;
    logic [N_CDB-1:0]             cdb_valid;
    logic [N_CDB*TAG_W-1:0]       cdb_tag;
    logic [N_CDB*DATA_W-1:0]      cdb_data;
    logic [N_ENTRIES_W:0]         count;

    modport master (
        output flush, i_valid, i_dest, i_instr, i_src_tag, i_src_data, i_filled,
        output o_ready, cdb_valid, cdb_tag, cdb_data,
        input  i_ready, o_valid, o_dest, o_instr, o_src_data, count
    );

    modport slave (
        input  flush, i_valid, i_dest, i_instr, i_src_tag, i_src_data, i_filled,
        input  o_ready, cdb_valid, cdb_tag, cdb_data,
        output i_ready, o_valid, o_dest, o_instr, o_src_data, count
    );
endinterface
`default_nettype wire

// File: rtl/reservation_station_ooo.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station_ooo
// Brief    : Multi-CDB reservation station, oldest-ready issue via age matrix.
//            Optional RSV_ISSUE_BYPASS_EN: same-cycle wake-up/dispatch issue.
// Revision : 1.0 - initial release
// ============================================================================
module reservation_station_ooo #(
    parameter int N_OPERANDS  = 2,
    parameter int N_ENTRIES_W = 3,
    parameter int N_CDB       = 2,
    parameter int TAG_W       = 4,
    parameter int DATA_W      = 32,
    parameter int INSTR_W     = 8
) (
    input  logic                      clk,
    input  logic                      nrst,
    reservation_station_ooo_if.slave  rs
);
    localparam int DEPTH = 1 << N_ENTRIES_W;
`ifdef RSV_ISSUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam logic [N_ENTRIES_W:0] CNT_ONE = {{N_ENTRIES_W{1'b0}}, 1'b1};

    typedef logic [N_ENTRIES_W-1:0] idx_t;

    // Returns {hit, data}; scanning downwards lets the lowest port win.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]        tag,
        input logic [N_CDB-1:0]        vld,
        input logic [N_CDB*TAG_W-1:0]  tags,
        input logic [N_CDB*DATA_W-1:0] data
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int p = N_CDB - 1; p >= 0; p--) begin
            if (vld[p] && tags[p*TAG_W +: TAG_W] == tag)
                res = {1'b1, data[p*DATA_W +: DATA_W]};
        end
        return res;
    endfunction

    logic [DEPTH-1:0]      ent_valid;
    logic [TAG_W-1:0]      ent_dest   [DEPTH];
    logic [INSTR_W-1:0]    ent_instr  [DEPTH];
    logic [TAG_W-1:0]      ent_tag    [DEPTH][N_OPERANDS];
    logic [DATA_W-1:0]     ent_data   [DEPTH][N_OPERANDS];
    logic [N_OPERANDS-1:0] ent_filled [DEPTH];
    // older[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0]      older      [DEPTH];
    logic [N_ENTRIES_W:0]  occ;
    logic                  hold_vld;
    idx_t                  hold_idx;

    logic [N_OPERANDS-1:0] wake_hit   [DEPTH];
    logic [DATA_W-1:0]     wake_data  [DEPTH][N_OPERANDS];
    logic [DATA_W-1:0]     eff_data   [DEPTH][N_OPERANDS];
    logic [N_OPERANDS-1:0] in_hit;
    logic [DATA_W-1:0]     in_val     [N_OPERANDS];
    logic [DEPTH-1:0]      ready;
    logic [DEPTH-1:0]      oldest;
    logic                  any_ready;
    idx_t                  oldest_idx;
    idx_t                  free_idx;
    idx_t                  pres_idx;
    logic                  disp;
    logic                  from_in;
    logic                  issue_ent;
    logic                  alloc;

    always_comb begin
        logic [DATA_W:0]       lk;
        logic [N_OPERANDS-1:0] eff_filled;
        lk = '0;
        for (int k = 0; k < N_OPERANDS; k++) begin
            lk        = cdb_lookup(rs.i_src_tag[k*TAG_W +: TAG_W], rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
            in_hit[k] = lk[DATA_W] & ~rs.i_filled[k];
            in_val[k] = rs.i_filled[k] ? rs.i_src_data[k*DATA_W +: DATA_W] : lk[DATA_W-1:0];
        end
        for (int i = 0; i < DEPTH; i++) begin
            eff_filled = '0;
            for (int k = 0; k < N_OPERANDS; k++) begin
                lk              = cdb_lookup(ent_tag[i][k], rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
                wake_hit[i][k]  = lk[DATA_W] & ent_valid[i] & ~ent_filled[i][k];
                wake_data[i][k] = lk[DATA_W-1:0];
                eff_filled[k]   = ent_filled[i][k] | (BYPASS & wake_hit[i][k]);
                eff_data[i][k]  = (BYPASS && wake_hit[i][k]) ? lk[DATA_W-1:0] : ent_data[i][k];
            end
            ready[i] = ent_valid[i] & (&eff_filled);
        end
    end

    always_comb begin
        oldest     = ready;
        oldest_idx = '0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && older[j][i])
                    oldest[i] = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (oldest[i])
                oldest_idx = idx_t'(i);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i])
                free_idx = idx_t'(i);
        end
    end

    assign any_ready  = |ready;
    assign rs.i_ready = ~occ[N_ENTRIES_W];
    assign rs.count   = occ;
    assign disp       = rs.i_valid & rs.i_ready & ~rs.flush;
    // A dispatch may only go straight out when nothing already held is ready
    assign from_in    = BYPASS & disp & (&(rs.i_filled | in_hit)) & ~any_ready & ~hold_vld;
    assign pres_idx   = hold_vld ? hold_idx : oldest_idx;
    assign rs.o_valid = hold_vld | any_ready | from_in;
    assign issue_ent  = rs.o_valid & rs.o_ready & ~rs.flush & ~from_in;
    assign alloc      = disp & ~(from_in & rs.o_ready);

    always_comb begin
        rs.o_dest  = from_in ? rs.i_dest  : ent_dest[pres_idx];
        rs.o_instr = from_in ? rs.i_instr : ent_instr[pres_idx];
        for (int k = 0; k < N_OPERANDS; k++)
            rs.o_src_data[k*DATA_W +: DATA_W] = from_in ? in_val[k] : eff_data[pres_idx][k];
    end

    always_ff @(posedge clk) begin
        if (nrst || rs.flush) begin
            occ       <= '0;
            hold_vld  <= 1'b0;
            hold_idx  <= '0;
            ent_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older[i]      <= '0;
                ent_filled[i] <= '0;
            end
        end else begin
            hold_vld <= rs.o_valid & ~rs.o_ready;
            hold_idx <= from_in ? free_idx : pres_idx;
            if (alloc && !issue_ent)
                occ <= occ + CNT_ONE;
            else if (issue_ent && !alloc)
                occ <= occ - CNT_ONE;
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc && free_idx == idx_t'(i)) begin
                    ent_valid[i]  <= 1'b1;
                    ent_filled[i] <= rs.i_filled | in_hit;
                    older[i]      <= '0;
                end else begin
                    if (issue_ent && pres_idx == idx_t'(i))
                        ent_valid[i] <= 1'b0;
                    ent_filled[i] <= ent_filled[i] | wake_hit[i];
                    if (alloc)
                        older[i][free_idx] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc && free_idx == idx_t'(i)) begin
                ent_dest[i]  <= rs.i_dest;
                ent_instr[i] <= rs.i_instr;
                for (int k = 0; k < N_OPERANDS; k++) begin
                    ent_tag[i][k]  <= rs.i_src_tag[k*TAG_W +: TAG_W];
                    ent_data[i][k] <= in_val[k];
                end
            end else begin
                for (int k = 0; k < N_OPERANDS; k++) begin
                    if (wake_hit[i][k])
                        ent_data[i][k] <= wake_data[i][k];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/reservation_station_ooo.md
Name: reservation_station_ooo

Overview:
- Successor to the single-CDB, in-order-fill reservation station.
- Holds up to 2**N_ENTRIES_W dispatched instructions, each with N_OPERANDS source operands.
- Captures missing operands from N_CDB parallel common-data-bus ports.
- Issues the oldest entry whose operands are all filled, with backpressure, a pipeline flush and an occupancy count. Sits between the dispatch stage and one functional unit.

Parameters:
- N_OPERANDS, 2, source operands per entry
- N_ENTRIES_W, 3, log2 of entry count (DEPTH = 2**N_ENTRIES_W)
- N_CDB, 2, number of CDB broadcast ports
- TAG_W, 4, ROB/rename tag width
- DATA_W, 32, operand data width
- INSTR_W, 8, opcode/control width

Ports:
- clk  in  1  clock
- nrst  in  1  reset: synchronous, active-high
- flush  in  1  discard all entries
- i_valid  in  1  dispatch request
- i_ready  out  1  entry free
- i_dest  in  TAG_W  destination tag
- i_instr  in  INSTR_W  opcode
- i_src_tag  in  N_OPERANDS*TAG_W  producer tag per operand
- i_src_data  in  N_OPERANDS*DATA_W  operand value (meaningful when filled)
- i_filled  in  N_OPERANDS  operand already available
- o_valid  out  1  issue request
- o_ready  in  1  functional unit accepts
- o_dest  out  TAG_W  destination tag of issued entry
- o_instr  out  INSTR_W  opcode of issued entry
- o_src_data  out  N_OPERANDS*DATA_W  operand values
- cdb_valid  in  N_CDB  per-port broadcast valid
- cdb_tag  in  N_CDB*TAG_W  per-port result tag
- cdb_data  in  N_CDB*DATA_W  per-port result value
- count  out  N_ENTRIES_W+1  occupied entries

Behaviour:
- Reset (nrst=1 at clk edge): all entries invalid; count=0, o_valid=0, i_ready=1; no age state retained. Reset mid-operation drops everything.
- flush behaves like reset for entry state. It dominates a same-cycle dispatch, CDB capture and issue: the issue is not considered taken and the dispatch is dropped.
- i_ready = (count < DEPTH), from registered state only. A dequeue in the same cycle does not free a slot for a dispatch when full.
- Dispatch (i_valid & i_ready): writes the lowest-index free entry. The entry is valid from the next cycle and is the youngest entry.
- Dispatch-cycle capture (mandatory): an unfilled operand whose tag matches a valid CDB port in the dispatch cycle is stored filled with that CDB data.
- Wake-up: each valid, unfilled operand compares its tag against all valid CDB ports every cycle. On a match it becomes filled with that data at the next edge. If several ports match, the lowest port index wins.
- Ready entry: valid and all operands filled.
- Select: o_valid=1 when any ready entry exists; the oldest ready entry (dispatch order) is presented.
- Outputs are combinational from registered state; latency from dispatch-with-all-filled to o_valid is 1 cycle.
- Hold rule: once o_valid=1 and o_ready=0, the presented entry and its outputs must remain unchanged until accepted, even if an older entry becomes ready.
- Issue (o_valid & o_ready): the presented entry is freed at the next edge.
- Simultaneous dispatch and issue changes count by 0.
- Age ordering must stay correct across arbitrary free-slot reuse; use an age matrix or equivalent.
- count is updated at each edge: +1 per dispatch, -1 per issue, 0 after flush/reset. It never exceeds DEPTH.

Optional Feature:
RSV_ISSUE_BYPASS_EN:
- Defined: an entry (or the incoming dispatch, when the station holds no ready entry) whose last missing operands match valid CDB ports in cycle t may issue in cycle t. The CDB data is forwarded combinationally to o_src_data, and the oldest-ready and hold rules still apply.
- Undefined: issue occurs no earlier than t+1 after capture. Dispatch never issues in its own cycle.

Test Plan:
- Dispatch 3 entries, all i_filled=2'b11, o_ready=1 -> issued in dispatch order, one per cycle, first o_valid one cycle after first dispatch; count 1,1,1 then 0.
- Entry A (older) waits on tag 5, entry B filled; hold o_ready=0 two cycles, then CDB0 tag 5 data 0xAA -> B remains presented until accepted, then A issues with operand 0xAA.
- Same cycle: CDB0 tag 3 data 0x11, CDB1 tag 7 data 0x22; entry waits on tags 3 and 7 -> both captured, o_src_data={0x22,0x11} next cycle (bypass off).
- Fill all DEPTH=8 entries with unready operands -> i_ready=0, count=8. Issue one in the same cycle as i_valid -> dispatch rejected; i_ready=1 one cycle later.
- Dispatch operand tag 9 unfilled while CDB1 broadcasts tag 9 data 0x55 -> entry filled with 0x55, issues next cycle.
- 4 entries held, assert flush together with i_valid and o_ready -> next cycle count=0, o_valid=0, dispatched entry absent. Repeat the same state with nrst=1 -> identical result.
